// File: rtl/cf_fft_1024_8_pkg.sv
// Shared parameters, FSM state types and index bit-reversal helper
// for the FFT output unscrambler.
package cf_fft_1024_8_pkg;

    localparam int DEF_LOG2N = 10;
    localparam int DEF_WIDTH = 16;
    localparam int MAX_LOG2N = 16;
    localparam int IDX_W     = 4;

    typedef enum logic {
        W_IDLE,
        W_FILL
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_READ
    } rd_state_t;

    // Reverse the low n bits of v; bits above n come back zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(
        input logic [MAX_LOG2N-1:0] v,
        input int                   n
    );
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < n) r[IDX_W'(i)] = v[IDX_W'(n - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/cf_fft_1024_8_dpram.sv
// Simple dual-port frame RAM: one write port, one registered read port,
// {bank,addr} addressing across two ping-pong frame banks.
module cf_fft_1024_8_dpram #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clock_c,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clock_c) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register only updates on a read, so it holds data during stalls.
    always_ff @(posedge clock_c) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/cf_fft_1024_8_unscramble.sv
// Bit-reversed to natural order frame reorder with ping-pong banks.
// Optional CF_FFT_DROP_COUNT_EN adds a saturating 8-bit drop_count output.
module cf_fft_1024_8_unscramble
    import cf_fft_1024_8_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock_c,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             in_start,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_start,
    output logic             out_last,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             drop
`ifdef CF_FFT_DROP_COUNT_EN
    ,
    output logic [7:0]       drop_count
`endif
);

    localparam logic [LOG2N-1:0] KMAX = '1;
    localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

    logic [1:0] rst_sync;
    logic       rst_n_i;

    // Assert immediately, release two clocks after reset_n rises.
    always_ff @(posedge clock_c or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n_i = rst_sync[1];

    wr_state_t        w_state, w_nx;
    logic [LOG2N-1:0] k, k_nx, kw, waddr_lo;
    logic             wbank, wbank_nx;
    logic             we, set_full, drop_nx, full_ok;

    rd_state_t        r_state, r_nx;
    logic [LOG2N-1:0] a, a_nx;
    logic             rbank, rbank_nx;
    logic             issue, clr_full;

    logic [1:0]           full, full_nx;
    logic [2*WIDTH-1:0]   rd_data;

    always_comb begin
        issue    = 1'b0;
        clr_full = 1'b0;
        r_nx     = r_state;
        a_nx     = a;
        rbank_nx = rbank;
        unique case (r_state)
            R_IDLE: begin
                if (full[rbank]) r_nx = R_READ;
            end
            R_READ: begin
                if (!out_valid || out_ready) begin
                    issue = 1'b1;
                    a_nx  = a + ONE;
                    if (a == KMAX) begin
                        clr_full = 1'b1;
                        rbank_nx = ~rbank;
                        r_nx     = full[~rbank] ? R_READ : R_IDLE;
                    end
                end
            end
            default: r_nx = R_IDLE;
        endcase
    end

    // A bank being released this cycle counts as free for a new frame.
    assign full_ok  = !full[wbank] || (clr_full && (rbank == wbank));
    assign kw       = in_start ? '0 : k;
    assign waddr_lo = LOG2N'(bitrev(MAX_LOG2N'(kw), LOG2N));

    always_comb begin
        we       = 1'b0;
        set_full = 1'b0;
        drop_nx  = 1'b0;
        w_nx     = w_state;
        k_nx     = k;
        wbank_nx = wbank;
        unique case (w_state)
            W_IDLE: begin
                if (ce && in_start) begin
                    if (full_ok) begin
                        we   = 1'b1;
                        k_nx = ONE;
                        w_nx = W_FILL;
                    end else begin
                        drop_nx = 1'b1;
                    end
                end
            end
            W_FILL: begin
                if (ce) begin
                    we = 1'b1;
                    if (in_start) begin
                        k_nx = ONE;
                    end else begin
                        k_nx = k + ONE;
                        if (k == KMAX) begin
                            set_full = 1'b1;
                            wbank_nx = ~wbank;
                            w_nx     = W_IDLE;
                        end
                    end
                end
            end
            default: w_nx = W_IDLE;
        endcase
    end

    always_comb begin
        full_nx = full;
        if (clr_full) full_nx[rbank] = 1'b0;
        if (set_full) full_nx[wbank] = 1'b1;
    end

    always_ff @(posedge clock_c or negedge rst_n_i) begin
        if (!rst_n_i) begin
            w_state <= W_IDLE;
            k       <= '0;
            wbank   <= 1'b0;
            r_state <= R_IDLE;
            a       <= '0;
            rbank   <= 1'b0;
            full    <= 2'b00;
            drop    <= 1'b0;
        end else begin
            w_state <= w_nx;
            k       <= k_nx;
            wbank   <= wbank_nx;
            r_state <= r_nx;
            a       <= a_nx;
            rbank   <= rbank_nx;
            full    <= full_nx;
            drop    <= drop_nx;
        end
    end

    always_ff @(posedge clock_c or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_last  <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_start <= (a == '0);
            out_last  <= (a == KMAX);
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef CF_FFT_DROP_COUNT_EN
    always_ff @(posedge clock_c or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_count <= 8'd0;
        end else if (drop_nx && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

    cf_fft_1024_8_dpram #(
        .AW (LOG2N + 1),
        .DW (2 * WIDTH)
    ) u_ram (
        .clock_c (clock_c),
        .we      (we),
        .waddr   ({wbank, waddr_lo}),
        .wdata   ({in_re, in_im}),
        .re      (issue),
        .raddr   ({rbank, a}),
        .rdata   (rd_data)
    );

    assign out_re = out_valid ? rd_data[2*WIDTH-1:WIDTH] : '0;
    assign out_im = out_valid ? rd_data[WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_cf_fft_1024_8_unscramble.sv
// Self-checking bench for cf_fft_1024_8_unscramble with LOG2N=3.
// Reference: natural output n carries the stream sample at index bitrev(n).
module tb_cf_fft_1024_8_unscramble;

    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int W     = 16;

    logic         clock_c = 1'b0;
    logic         reset_n;
    logic         ce;
    logic         in_start;
    logic [W-1:0] in_re;
    logic [W-1:0] in_im;
    logic         out_valid;
    logic         out_ready;
    logic         out_start;
    logic         out_last;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic         drop;
`ifdef CF_FFT_DROP_COUNT_EN
    logic [7:0]   drop_count;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int rdy_mode  = 0;
    int drop_seen = 0;
    int run       = 0;
    int max_run   = 0;
    int d0;

    logic [33:0]  exp_q[$];
    logic [W-1:0] fr_re[N];
    logic [W-1:0] fr_im[N];

    cf_fft_1024_8_unscramble #(
        .LOG2N (LOG2N),
        .WIDTH (W)
    ) dut (
        .clock_c   (clock_c),
        .reset_n   (reset_n),
        .ce        (ce),
        .in_start  (in_start),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_start (out_start),
        .out_last  (out_last),
        .out_re    (out_re),
        .out_im    (out_im),
        .drop      (drop)
`ifdef CF_FFT_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clock_c = ~clock_c;

    function automatic int rev(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) r = r * 2 + ((v >> i) & 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Consumer-side ready pattern
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock_c);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor against the expected-sample queue
    always @(negedge clock_c) begin
        if (drop) drop_seen++;
        if (out_valid) begin
            run++;
            if (run > max_run) max_run = run;
            if (exp_q.size() == 0) begin
                chk("out_while_empty", 64'(out_valid), 64'd0);
            end else begin
                chk("out_sample", {30'b0, out_re, out_im, out_start, out_last},
                    64'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end else begin
            run = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock_c);
            #1;
            ce       = 1'b0;
            in_start = 1'b0;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < N; k++) begin
            fr_re[k] = W'($urandom);
            fr_im[k] = W'($urandom);
        end
    endtask

    task automatic send_frame(input bit accept, input int gaps);
        for (int k = 0; k < N; k++) begin
            if (gaps > 0 && k > 0) begin
                repeat ($urandom_range(0, gaps)) begin
                    @(posedge clock_c);
                    #1;
                    ce       = 1'b0;
                    in_start = 1'b0;
                end
            end
            @(posedge clock_c);
            #1;
            ce       = 1'b1;
            in_start = (k == 0);
            in_re    = fr_re[k];
            in_im    = fr_im[k];
        end
        if (accept) begin
            for (int n = 0; n < N; n++) begin
                exp_q.push_back({fr_re[rev(n)], fr_im[rev(n)],
                                 1'(n == 0), 1'(n == N - 1)});
            end
        end
    endtask

    task automatic drain(input string tag);
        int c = 0;
        while (exp_q.size() != 0 && c < 400) begin
            @(posedge clock_c);
            c++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clock_c);
        #1;
        chk({tag, "_idle"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b1;
        ce       = 1'b0;
        in_start = 1'b0;
        in_re    = '0;
        in_im    = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock_c);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_flags", 64'({out_start, out_last, drop}), 64'd0);
        chk("rst_data", 64'({out_re, out_im}), 64'd0);
`ifdef CF_FFT_DROP_COUNT_EN
        chk("rst_drop_count", 64'(drop_count), 64'd0);
`endif
        @(posedge clock_c);
        #1 reset_n = 1'b1;
        idle(4);

        // Single frame: stream k carries bitrev(k), output counts up
        rdy_mode = 0;
        for (int k = 0; k < N; k++) begin
            fr_re[k] = W'(rev(k));
            fr_im[k] = W'(-rev(k));
        end
        send_frame(1'b1, 0);
        idle(1);
        chk("lat_t0", 64'(out_valid), 64'd0);
        idle(1);
        chk("lat_t1", 64'(out_valid), 64'd0);
        idle(1);
        chk("lat_t2_valid", 64'(out_valid), 64'd1);
        chk("lat_t2_start", 64'(out_start), 64'd1);
        drain("frame1");

        // Back-to-back frames, no bubbles on the output
        max_run = 0;
        for (int k = 0; k < N; k++) fr_re[k] = W'(rev(k));
        send_frame(1'b1, 0);
        for (int k = 0; k < N; k++) fr_re[k] = W'(rev(k) + 8);
        send_frame(1'b1, 0);
        idle(1);
        drain("b2b");
        chk("b2b_run", 64'(max_run), 64'd16);
        chk("b2b_nodrop", 64'(drop_seen), 64'd0);

        // Ready toggling every cycle
        rdy_mode = 1;
        fill_rand();
        send_frame(1'b1, 0);
        fill_rand();
        send_frame(1'b1, 0);
        idle(1);
        drain("toggle");

        // Stalled consumer: third frame dropped
        rdy_mode = 2;
        idle(2);
        d0 = drop_seen;
        fill_rand();
        send_frame(1'b1, 0);
        fill_rand();
        send_frame(1'b1, 0);
        fill_rand();
        send_frame(1'b0, 0);
        idle(4);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_start", 64'(out_start), 64'd1);
        chk("stall_drops", 64'(drop_seen - d0), 64'd1);
`ifdef CF_FFT_DROP_COUNT_EN
        chk("drop_count", 64'(drop_count), 64'd1);
`endif
        rdy_mode = 0;
        drain("stall");

        // Restart at k=5 discards the partial frame
        d0 = drop_seen;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock_c);
            #1;
            ce       = 1'b1;
            in_start = (k == 0);
            in_re    = 16'hDEAD;
            in_im    = W'(k);
        end
        fill_rand();
        send_frame(1'b1, 0);
        idle(1);
        drain("abort");
        chk("abort_nodrop", 64'(drop_seen - d0), 64'd0);

        // Random ready and input gaps
        rdy_mode = 3;
        d0 = drop_seen;
        for (int r = 0; r < 3; r++) begin
            fill_rand();
            send_frame(1'b1, 2);
            fill_rand();
            send_frame(1'b1, 2);
            idle(1);
            drain("random");
        end
        chk("random_nodrop", 64'(drop_seen - d0), 64'd0);

        // Reset while draining
        rdy_mode = 1;
        fill_rand();
        send_frame(1'b1, 0);
        idle(4);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'({out_re, out_start}), 64'd0);
`ifdef CF_FFT_DROP_COUNT_EN
        chk("mid_rst_drop_count", 64'(drop_count), 64'd0);
`endif
        exp_q.delete();
        idle(3);
        reset_n = 1'b1;
        idle(4);
        rdy_mode = 0;
        fill_rand();
        send_frame(1'b1, 0);
        idle(1);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
